sap_datapath: RTL
=================

Name: sap_datapath

Overview:
- 8-bit SAP-1 datapath that sits directly downstream of the microcode controller.
- Consumes the 12-bit control word, drives the shared bus, and holds PC, MAR, RAM, IR, A, B, ALU and flags.
- Returns the IR opcode nibble to the controller.
- Includes a program-load port so a bench or host can fill RAM before a run.

Parameters:
- DATA_W, 8: bus/register/RAM word width (minimum 8; opcode is always the top 4 bits of IR).
- ADDR_W, 4: PC/MAR width; RAM depth = 2**ADDR_W.

Ports:
- clk  in  1  datapath clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- ctrl  in  12  control word. Bit map: 11 HLT, 10 PC_INC, 9 PC_EN, 8 MEM_LOAD (MAR load), 7 MEM_EN, 6 IR_LOAD, 5 IR_EN, 4 A_LOAD, 3 A_EN, 2 B_LOAD, 1 ADDER_SUB, 0 ADDER_EN.
- prog_mode  in  1  high: datapath frozen, RAM writable from the program port.
- prog_we  in  1  RAM write strobe; honoured only when prog_mode=1.
- prog_addr  in  ADDR_W  program-port write address.
- prog_data  in  DATA_W  program-port write data.
- opcode  out  4  IR[DATA_W-1:DATA_W-4], to the controller.
- a_out  out  DATA_W  A register contents.
- bus  out  DATA_W  current bus value (debug/observation).
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- halted  out  1  sticky halt flag.
- bus_conflict  out  1  registered flag; more than one bus driver was seen.

Behaviour:
- Timing: ctrl is stable across each posedge. The controller changes it on negedge; the datapath samples on posedge.
- Reset (async): PC, MAR, IR, A, B, carry, zero, halted and bus_conflict all clear to 0. RAM contents are NOT cleared.
- Bus is combinational:
  - PC_EN: {0, PC}.
  - MEM_EN: RAM[MAR] (asynchronous read).
  - IR_EN: {0, IR[ADDR_W-1:0]}.
  - A_EN: A.
  - ADDER_EN: ALU result.
  - No driver: bus = 0.
- Multiple bus drivers:
  - Priority is MEM_EN > IR_EN > PC_EN > ADDER_EN > A_EN.
  - bus_conflict is set on the next posedge and stays set until reset.
- ALU (combinational):
  - ADDER_SUB=0: {c, r} = A + B.
  - ADDER_SUB=1: {c, r} = A + ~B + 1. carry = c, so carry=1 means no borrow.
  - All arithmetic wraps mod 2**DATA_W.
- Posedge updates, applied only when halted=0 and prog_mode=0:
  - PC_INC: PC <= PC+1, wrapping from 2**ADDR_W-1 to 0.
  - MEM_LOAD: MAR <= bus[ADDR_W-1:0].
  - IR_LOAD: IR <= bus.
  - A_LOAD: A <= bus.
  - B_LOAD: B <= bus.
  - ADDER_EN: carry <= c and zero <= (r==0). Flags otherwise hold.
  - HLT: halted <= 1.
- Simultaneous load and drive of the same register (e.g. A_EN with A_LOAD) is legal: the register reloads its own value. Loads use the pre-edge bus.
- Halt:
  - Once halted=1, all register and flag updates are suppressed; only rst clears halted.
  - A HLT asserted together with other bits in the same cycle: the other bits still take effect on that edge, and halted sets on the same edge.
- Program mode:
  - prog_mode=1 suppresses all register updates; halted holds.
  - prog_we writes RAM[prog_addr] <= prog_data on posedge.
  - prog_we with prog_mode=0 is ignored.
- Reset mid-instruction: registers clear immediately (async); the RAM contents and any write in progress on the same edge are unaffected.
- No output is registered except the state listed above. opcode, bus and a_out track register contents with zero latency.

Test Plan:
- Reset/load:
  - rst pulse → all registers, flags, halted and bus_conflict read 0; opcode=0.
  - With prog_mode=1, write RAM[0]=0x1E and RAM[14]=0x2A, then read back via MEM_EN with MAR=14 → bus=0x2A.
- LDA sequence, driving ctrl per stage:
  - PC_EN|MEM_LOAD; PC_INC; MEM_EN|IR_LOAD; IR_EN|MEM_LOAD; MEM_EN|A_LOAD.
  - Expect opcode=1, MAR=14, A=0x2A, PC=1.
- ADD with carry: A=0xF0, B loaded 0x20, then ADDER_EN|A_LOAD → A=0x10, carry=1, zero=0.
- SUB to zero: A=0x33, B=0x33, then ADDER_SUB|ADDER_EN|A_LOAD → A=0x00, zero=1, carry=1.
- SUB with borrow: A=0x01, B=0x02 → A=0xFF, carry=0, zero=0.
- PC wrap and halt:
  - 16 PC_INC cycles → PC=0.
  - HLT asserted → halted=1; later A_LOAD/PC_INC have no effect until rst.
- Bus conflict: assert MEM_EN|A_EN together → bus=RAM[MAR], bus_conflict=1 after the edge, and it stays set until reset.

Source files
------------

// File: rtl/sap_datapath.sv
// SAP-1 datapath: shared bus, PC/MAR/RAM/IR/A/B, adder/subtractor and flags.
// Consumes the controller's 12-bit control word and returns the IR opcode nibble.
// bus_conflict is an observation flag, so it keeps recording even while frozen.
module sap_datapath #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [11:0]       ctrl,
   input  logic              prog_mode,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic [3:0]        opcode,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] bus,
   output logic              carry,
   output logic              zero,
   output logic              halted,
   output logic              bus_conflict
);

   localparam int unsigned RAM_D = 1 << ADDR_W;
   localparam int unsigned SUM_W = DATA_W + 1;

   logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load;
   logic ir_en, a_load, a_en, b_load, adder_sub, adder_en;

   assign hlt       = ctrl[11];
   assign pc_inc    = ctrl[10];
   assign pc_en     = ctrl[9];
   assign mem_load  = ctrl[8];
   assign mem_en    = ctrl[7];
   assign ir_load   = ctrl[6];
   assign ir_en     = ctrl[5];
   assign a_load    = ctrl[4];
   assign a_en      = ctrl[3];
   assign b_load    = ctrl[2];
   assign adder_sub = ctrl[1];
   assign adder_en  = ctrl[0];

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] a_reg;
   logic [DATA_W-1:0] b_reg;
   logic [DATA_W-1:0] ram [RAM_D];

   logic [DATA_W-1:0] b_opnd;
   logic [SUM_W-1:0]  alu_sum;
   logic [2:0]        drv_cnt;
   logic              multi_drv;
   logic              upd_en;

   // Adder/subtractor: subtraction is A + ~B + 1, carry out means no borrow
   always_comb begin
      b_opnd  = adder_sub ? ~b_reg : b_reg;
      alu_sum = SUM_W'(a_reg) + SUM_W'(b_opnd) + SUM_W'(adder_sub);
   end

   // Count bus drivers to detect contention
   always_comb begin
      drv_cnt   = 3'(mem_en) + 3'(ir_en) + 3'(pc_en) + 3'(adder_en) + 3'(a_en);
      multi_drv = (drv_cnt > 3'd1);
   end

   // Bus mux with fixed priority MEM > IR > PC > ADDER > A, idle bus reads 0
   always_comb begin
      bus = '0;
      if (mem_en)        bus = ram[mar];
      else if (ir_en)    bus = DATA_W'(ir[ADDR_W-1:0]);
      else if (pc_en)    bus = DATA_W'(pc);
      else if (adder_en) bus = alu_sum[DATA_W-1:0];
      else if (a_en)     bus = a_reg;
   end

   assign upd_en = !halted && !prog_mode;
   assign opcode = ir[DATA_W-1:DATA_W-4];
   assign a_out  = a_reg;

   // Architectural register and flag updates, frozen when halted or programming
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= '0;
         mar          <= '0;
         ir           <= '0;
         a_reg        <= '0;
         b_reg        <= '0;
         carry        <= 1'b0;
         zero         <= 1'b0;
         halted       <= 1'b0;
         bus_conflict <= 1'b0;
      end else begin
         if (multi_drv) bus_conflict <= 1'b1;
         if (upd_en) begin
            if (pc_inc)   pc    <= pc + ADDR_W'(1);
            if (mem_load) mar   <= bus[ADDR_W-1:0];
            if (ir_load)  ir    <= bus;
            if (a_load)   a_reg <= bus;
            if (b_load)   b_reg <= bus;
            if (adder_en) begin
               carry <= alu_sum[DATA_W];
               zero  <= (alu_sum[DATA_W-1:0] == '0);
            end
            if (hlt)      halted <= 1'b1;
         end
      end
   end

   // Program-port RAM write; RAM has no reset so contents survive rst
   always_ff @(posedge clk) begin
      if (prog_mode && prog_we) ram[prog_addr] <= prog_data;
   end

endmodule
